// File: rtl/alu_pkg.sv
// Shared types for the slice-serial ALU: function codes, FSM states, slice width,
// and the bitwise-logic function table used by the 4-bit slice.
package alu_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [3:0] {
      FUNC_00 = 4'd0,
      FUNC_01 = 4'd1,
      FUNC_02 = 4'd2,
      FUNC_03 = 4'd3,
      FUNC_04 = 4'd4,
      FUNC_05 = 4'd5,
      FUNC_06 = 4'd6,
      FUNC_07 = 4'd7,
      FUNC_08 = 4'd8,
      FUNC_09 = 4'd9,
      FUNC_10 = 4'd10,
      FUNC_11 = 4'd11,
      FUNC_12 = 4'd12,
      FUNC_13 = 4'd13,
      FUNC_14 = 4'd14,
      FUNC_15 = 4'd15
   } func_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [SLICE_W-1:0] logic_fn(input func_e fn,
                                                   input logic [SLICE_W-1:0] a,
                                                   input logic [SLICE_W-1:0] b);
      logic [SLICE_W-1:0] r;
      r = a;
      case (fn)
         FUNC_00: r = ~a;
         FUNC_01: r = ~(a | b);
         FUNC_02: r = ~a & b;
         FUNC_03: r = '0;
         FUNC_04: r = ~(a & b);
         FUNC_05: r = ~b;
         FUNC_06: r = a ^ b;
         FUNC_07: r = a & ~b;
         FUNC_08: r = ~a | b;
         FUNC_09: r = ~(a ^ b);
         FUNC_10: r = b;
         FUNC_11: r = a & b;
         FUNC_12: r = '1;
         FUNC_13: r = a | ~b;
         FUNC_14: r = a | b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_slice_seq_if.sv
// Request/response bundle of the slice-serial ALU: operation request handshake,
// operands and result handshake.
interface alu_slice_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       s;
   logic             m;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             cout;
   logic             a_eq_b;

   modport master (
      output in_valid, a, b, s, m, cin, out_ready,
      input  in_ready, out_valid, f, cout, a_eq_b
   );

   modport slave (
      input  in_valid, a, b, s, m, cin, out_ready,
      output in_ready, out_valid, f, cout, a_eq_b
   );
endinterface

// File: rtl/alu_slice4.sv
// Combinational 4-bit ALU slice: bitwise logic table when m=1, otherwise
// the T1 + T2 + cin arithmetic form with a carry out.
module alu_slice4
   import alu_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  func_e              s,
   input  logic               m,
   input  logic               cin,
   output logic [SLICE_W-1:0] f,
   output logic               cout
);

   logic [3:0]         sel;
   logic [SLICE_W-1:0] t1;
   logic [SLICE_W-1:0] t2;
   logic [SLICE_W:0]   sum;

   assign sel = s;

   // Select bits gate which operand terms feed the adder inputs
   assign t1  = a | ({SLICE_W{sel[0]}} & b) | ({SLICE_W{sel[1]}} & ~b);
   assign t2  = ({SLICE_W{sel[2]}} & a & ~b) | ({SLICE_W{sel[3]}} & a & b);
   assign sum = {1'b0, t1} + {1'b0, t2} + {{SLICE_W{1'b0}}, cin};

   always_comb begin
      f    = sum[SLICE_W-1:0];
      cout = sum[SLICE_W];
      if (m) begin
         f    = logic_fn(s, a, b);
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/alu_slice_seq.sv
// Slice-serial ALU: one alu_slice4 reused over NSLICE cycles per operation.
// Define ALU_SLICE_SEQ_ARITH_EN to build the arithmetic (m=0) path and carry chain.
module alu_slice_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic            clk,
   input logic            rst_n,
   alu_slice_seq_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_e             state_reg;
   state_e             state_next;
   logic               accept;
   logic               step;
   logic               last_slice;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   func_e              s_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [WIDTH-1:0]   f_reg;
   logic [WIDTH-1:0]   f_next;
   logic               a_eq_b_reg;

   logic [SLICE_W-1:0] a_sl [NSLICE];
   logic [SLICE_W-1:0] b_sl [NSLICE];
   logic [SLICE_W-1:0] slice_f;
   logic               slice_cout;
   logic               slice_m;
   logic               slice_cin;

   assign last_slice = (idx_reg == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      step       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (last_slice) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Return to IDLE only; acceptance waits for the following cycle
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   generate
      for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
         assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
         assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
         assign f_next[gi*SLICE_W +: SLICE_W] =
            (idx_reg == IDX_W'(gi)) ? slice_f : f_reg[gi*SLICE_W +: SLICE_W];
      end
   endgenerate

   alu_slice4 u_slice (
      .a    (a_sl[idx_reg]),
      .b    (b_sl[idx_reg]),
      .s    (s_reg),
      .m    (slice_m),
      .cin  (slice_cin),
      .f    (slice_f),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         s_reg      <= FUNC_00;
         idx_reg    <= '0;
         f_reg      <= '0;
         a_eq_b_reg <= 1'b0;
      end else begin
         if (accept) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            s_reg   <= func_e'(bus.s);
            idx_reg <= '0;
         end
         if (step) begin
            f_reg <= f_next;
            if (last_slice) begin
               a_eq_b_reg <= &f_next;
            end else begin
               idx_reg <= idx_reg + IDX_W'(1);
            end
         end
      end
   end

`ifdef ALU_SLICE_SEQ_ARITH_EN
   logic m_reg;
   logic carry_reg;
   logic cout_reg;

   // carry_reg starts each operation holding cin, the carry into slice 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reg     <= 1'b0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
      end else begin
         if (accept) begin
            m_reg     <= bus.m;
            carry_reg <= bus.cin;
         end
         if (step) begin
            carry_reg <= slice_cout;
            if (last_slice) begin
               cout_reg <= slice_cout;
            end
         end
      end
   end

   assign slice_m   = m_reg;
   assign slice_cin = carry_reg;
   assign bus.cout  = cout_reg;
`else
   logic unused_bits;

   assign slice_m     = 1'b1;
   assign slice_cin   = 1'b0;
   assign bus.cout    = 1'b0;
   assign unused_bits = ^{bus.m, bus.cin, slice_cout};
`endif

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.f         = f_reg;
   assign bus.a_eq_b    = a_eq_b_reg;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Self-checking bench for alu_slice_seq (WIDTH=16): vector table, stall/reset
// sequences and random operations against a full-width reference model.
module tb_alu_slice_seq;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  s;
      logic        m;
      logic        cin;
      logic [15:0] f;
      logic        cout;
      logic        aeb;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs[$];

   alu_slice_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_slice_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: arithmetic is the full-width sum T1 + T2 + cin, logic is the function table
   function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] s, input logic m, input logic cin,
                                     output logic [15:0] f, output logic co, output logic aeb);
      logic        arith;
      logic [15:0] t1;
      logic [15:0] t2;
      logic [16:0] sum;
`ifdef ALU_SLICE_SEQ_ARITH_EN
      arith = !m;
`else
      arith = 1'b0;
`endif
      co = 1'b0;
      if (arith) begin
         t1  = a | ({16{s[0]}} & b) | ({16{s[1]}} & ~b);
         t2  = ({16{s[2]}} & a & ~b) | ({16{s[3]}} & a & b);
         sum = 17'(t1) + 17'(t2) + 17'(cin);
         f   = sum[15:0];
         co  = sum[16];
      end else begin
         case (s)
            4'd0:    f = ~a;
            4'd1:    f = ~(a | b);
            4'd2:    f = ~a & b;
            4'd3:    f = 16'h0000;
            4'd4:    f = ~(a & b);
            4'd5:    f = ~b;
            4'd6:    f = a ^ b;
            4'd7:    f = a & ~b;
            4'd8:    f = ~a | b;
            4'd9:    f = ~(a ^ b);
            4'd10:   f = b;
            4'd11:   f = a & b;
            4'd12:   f = 16'hFFFF;
            4'd13:   f = a | ~b;
            4'd14:   f = a | b;
            default: f = a;
         endcase
      end
      aeb = &f;
   endfunction

   task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input logic [15:0] f,
                          input logic cout, input logic aeb);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.m = m; v.cin = cin;
      v.f = f; v.cout = cout; v.aeb = aeb;
      vecs.push_back(v);
   endtask

   // Waits for IDLE, presents the operation and returns at the negedge after acceptance
   task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                            input logic m, input logic cin);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.cin = cin;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Scrambles inputs while busy; counts cycles from the acceptance edge to out_valid
   task automatic wait_valid(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.out_valid) break;
         bus.in_valid = 1'($urandom);
         bus.a   = 16'($urandom);
         bus.b   = 16'($urandom);
         bus.s   = 4'($urandom);
         bus.m   = 1'($urandom);
         bus.cin = 1'($urandom);
      end
      bus.in_valid = 1'b0;
      chk("latency", 32'(lat), 32'(NSLICE));
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
      chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s, input logic m, input logic cin,
                         input logic [15:0] ef, input logic ecout, input logic eaeb);
      int lat;
      accept_op(a, b, s, m, cin);
      wait_valid(lat);
      $display("%s: a=%h b=%h s=%0d m=%0b cin=%0b -> f=%h cout=%0b aeb=%0b lat=%0d (exp f=%h cout=%0b aeb=%0b)",
               tag, a, b, s, m, cin, bus.f, bus.cout, bus.a_eq_b, lat, ef, ecout, eaeb);
      chk({tag, "_f"}, 32'(bus.f), 32'(ef));
      chk({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
      chk({tag, "_a_eq_b"}, 32'(bus.a_eq_b), 32'(eaeb));
      handshake();
   endtask

   initial begin
      logic [15:0] ra, rb, ef, stall_f;
      logic [3:0]  rs;
      logic        rm, rcin, ec, eaeb;
      int          lat;

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cin = 1'b0;

      add_vec(16'hF0F0, 16'hFF00, 4'd6,  1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0);
      add_vec(16'h1234, 16'h5678, 4'd12, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      add_vec(16'h1234, 16'h5678, 4'd3,  1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
      add_vec(16'h1234, 16'h0000, 4'd15, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
      add_vec(16'h00FF, 16'h0F0F, 4'd9,  1'b1, 1'b0, 16'hF00F, 1'b0, 1'b0);
      add_vec(16'h1234, 16'h5678, 4'd0,  1'b1, 1'b0, 16'hEDCB, 1'b0, 1'b0);
`ifdef ALU_SLICE_SEQ_ARITH_EN
      add_vec(16'hFFFF, 16'h0001, 4'd9,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      add_vec(16'h1234, 16'h1234, 4'd6,  1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      add_vec(16'h1234, 16'h1234, 4'd6,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      add_vec(16'h1234, 16'h0000, 4'd15, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
      add_vec(16'h0005, 16'h0000, 4'd0,  1'b0, 1'b1, 16'h0006, 1'b0, 1'b0);
`else
      add_vec(16'h00FF, 16'h0F0F, 4'd9,  1'b0, 1'b0, 16'hF00F, 1'b0, 1'b0);
      add_vec(16'hFFFF, 16'h0001, 4'd9,  1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_f", 32'(bus.f), 32'd0);
      chk("reset_cout", 32'(bus.cout), 32'd0);
      chk("reset_a_eq_b", 32'(bus.a_eq_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m,
                vecs[i].cin, vecs[i].f, vecs[i].cout, vecs[i].aeb);
      end

      // Consumer stalls in DONE while new requests arrive
      ref_model(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0, stall_f, ec, eaeb);
      accept_op(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2) == 0;
         bus.a = 16'($urandom); bus.b = 16'($urandom); bus.s = 4'($urandom);
         @(posedge clk);
         @(negedge clk);
         $display("stall%0d: f=%h out_valid=%0b in_ready=%0b", i, bus.f, bus.out_valid, bus.in_ready);
         chk("stall_f", 32'(bus.f), 32'(stall_f));
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b1;
      handshake();
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("no_accept_on_release", 32'(bus.in_ready), 32'd1);

      // Reset while BUSY at idx=2 with a partial result already written
      accept_op(16'hABCD, 16'h0000, 4'd15, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("reset_busy: f=%h cout=%0b aeb=%0b out_valid=%0b", bus.f, bus.cout, bus.a_eq_b, bus.out_valid);
      chk("abort_f", 32'(bus.f), 32'd0);
      chk("abort_cout", 32'(bus.cout), 32'd0);
      chk("abort_a_eq_b", 32'(bus.a_eq_b), 32'd0);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      ref_model(16'h0F0F, 16'h3C3C, 4'd14, 1'b1, 1'b0, ef, ec, eaeb);
      run_op("post_reset", 16'h0F0F, 16'h3C3C, 4'd14, 1'b1, 1'b0, ef, ec, eaeb);

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
         rm = 1'($urandom); rcin = 1'($urandom);
         if (i % 8 == 0) rb = ra;
         ref_model(ra, rb, rs, rm, rcin, ef, ec, eaeb);
         run_op($sformatf("rnd%0d", i), ra, rb, rs, rm, rcin, ef, ec, eaeb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
